load_store_unit: RTL and testbench

Multi-cycle data-memory access stage placed directly downstream of the ALU/immediate stage. It takes the ALU result as a byte address, plus the store data and the load/store width code, and runs one bus transaction per access. It handles byte enables, store-data replication, load extraction with sign or zero extension, alignment checking and a bus timeout. While a transaction is in flight it holds the core with `stall`.

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle data-memory access stage with bus timeout
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   memread, memwrite       load / store request from the current instruction
//   funct3                  access width and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   aluresult               byte address
//   writedata               store data (rs2)
//   readdata                extended load result, registered
//   stall                   holds PC and register file while an access is in flight
//   fault                   one-cycle pulse on misaligned, illegal or timed-out access
//   bus_req/bus_we          transaction request, 1 = write
//   bus_addr/bus_be         word address and byte enables
//   bus_wdata               replicated store data
//   bus_ack/bus_rdata       completion strobe and read word (same cycle)

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluresult,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [15:0] cnt;
    logic        tflag;
    logic [1:0]  off_q;
    logic        uns_q;
    logic [1:0]  width_q;

    logic        access, load_ok, store_ok, illegal, misaligned, bad;
    logic        start, timeout, load_ack;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_val;

    // Access legality and bus pattern for the request currently presented.
    always_comb begin
        access   = memread | memwrite;
        load_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
        store_ok = (funct3 <= 3'b010);
        illegal  = (memread & memwrite) | (memread & ~load_ok) | (memwrite & ~store_ok);
        misaligned = ((funct3[1:0] == 2'b10) && (aluresult[1:0] != 2'b00)) ||
                     ((funct3[1:0] == 2'b01) && aluresult[0]);
        bad      = access & (illegal | misaligned);

        be_c    = 4'b1111;
        wdata_c = writedata;
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << aluresult[1:0];
                wdata_c = {4{writedata[7:0]}};
            end
            2'b01: begin
                be_c    = aluresult[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{writedata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = writedata;
            end
        endcase
        if (!memwrite) begin
            wdata_c = 32'd0;
        end
    end

    // Load extraction uses the lane offset and width captured at request time.
    always_comb begin
        rbyte = 8'(bus_rdata >> {off_q, 3'b000});
        rhalf = 16'(bus_rdata >> {off_q[1], 4'b0000});
        case (width_q)
            2'b00:   load_val = {{24{rbyte[7] & ~uns_q}}, rbyte};
            2'b01:   load_val = {{16{rhalf[15] & ~uns_q}}, rhalf};
            default: load_val = bus_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        fault      = 1'b0;
        start      = 1'b0;
        timeout    = 1'b0;
        load_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (bad) begin
                    fault = 1'b1;
                end else if (access) begin
                    stall      = 1'b1;
                    start      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ack) begin
                    load_ack   = ~bus_we;
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                fault      = tflag;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus_req = (state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            tflag     <= 1'b0;
            off_q     <= 2'd0;
            uns_q     <= 1'b0;
            width_q   <= 2'd0;
            readdata  <= 32'd0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            state <= state_next;
            if (start) begin
                cnt       <= 16'd0;
                tflag     <= 1'b0;
                off_q     <= aluresult[1:0];
                uns_q     <= funct3[2];
                width_q   <= funct3[1:0];
                bus_we    <= memwrite;
                bus_addr  <= {aluresult[31:2], 2'b00};
                bus_be    <= be_c;
                bus_wdata <= wdata_c;
            end else if (state == REQ) begin
                cnt <= cnt + 16'd1;
                if (timeout) begin
                    tflag    <= 1'b1;
                    readdata <= 32'd0;
                end else if (load_ack) begin
                    readdata <= load_val;
                end
            end else if (state == DONE) begin
                tflag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memread, memwrite;
    logic [2:0]  funct3;
    logic [31:0] aluresult, writedata;
    logic [31:0] readdata;
    logic        stall, fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    int          st_cnt, rq_cnt;
    logic        done_seen, flt_done, flt_any, req_seen_bad;
    logic [31:0] rd_done, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memread   (memread),
        .memwrite  (memwrite),
        .funct3    (funct3),
        .aluresult (aluresult),
        .writedata (writedata),
        .readdata  (readdata),
        .stall     (stall),
        .fault     (fault),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one access right after a rising edge and runs it to the first
    // non-stalled cycle (DONE, or the fault cycle). ack_at = N acks in the
    // N-th REQ cycle; 0 never acks.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] rdat);
        memread = rd; memwrite = wr; funct3 = f3; aluresult = a; writedata = wd;
        bus_rdata = rdat;
        st_cnt = 0; rq_cnt = 0; done_seen = 1'b0; flt_done = 1'b0; flt_any = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            bus_ack = bus_req && (rq_cnt == ack_at - 1);
            @(negedge clk);
            if (fault && stall) flt_any = 1'b1;
            if (bus_req) begin
                rq_cnt++;
                cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata; cap_we = bus_we;
            end
            if (stall) st_cnt++;
            else begin
                done_seen = 1'b1;
                flt_done  = fault;
                rd_done   = readdata;
            end
            @(posedge clk); #1;
        end
        bus_ack = 1'b0; memread = 1'b0; memwrite = 1'b0;
        chk("access_completes", {31'd0, done_seen}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; funct3 = 3'd0;
        aluresult = 32'd0; writedata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_outs", {bus_we, bus_be, 27'd0} | bus_addr | bus_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SW, immediate ack
        run(1'b0, 1'b1, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF, 1, 32'h0);
        chk("sw_addr", cap_addr, 32'h1000_0008);
        chk("sw_be", {28'd0, cap_be}, 32'hF);
        chk("sw_we", {31'd0, cap_we}, 32'd1);
        chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("sw_stalls", st_cnt, 2);
        chk("sw_fault", {31'd0, flt_done | flt_any}, 32'd0);

        // SB / SH, back to back
        run(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_00A5, 1, 32'h0);
        chk("sb_be", {28'd0, cap_be}, 32'h8);
        chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", cap_addr, 32'h10);
        run(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_1234, 1, 32'h0);
        chk("sh_be", {28'd0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'h1234_1234);
        chk("store_keeps_readdata", rd_done, 32'd0);

        // LB / LBU, ack in the 3rd REQ cycle
        run(1'b1, 1'b0, 3'b000, 32'h21, 32'h0, 3, 32'h0000_8000);
        chk("lb_data", rd_done, 32'hFFFF_FF80);
        chk("lb_stalls", st_cnt, 4);
        chk("lb_be", {28'd0, cap_be}, 32'h2);
        chk("lb_we_wdata", {31'd0, cap_we} | cap_wdata, 32'd0);
        chk("lb_addr", cap_addr, 32'h20);
        run(1'b1, 1'b0, 3'b100, 32'h21, 32'h0, 3, 32'h0000_8000);
        chk("lbu_data", rd_done, 32'h0000_0080);

        // Misaligned and illegal: fault pulse, no stall, no bus request
        run(1'b1, 1'b0, 3'b010, 32'h02, 32'h0, 1, 32'hFFFF_FFFF);
        chk("lw_mis_fault", {31'd0, flt_done}, 32'd1);
        chk("lw_mis_stall_req", st_cnt + rq_cnt, 0);
        chk("lw_mis_readdata", rd_done, 32'h0000_0080);
        run(1'b1, 1'b0, 3'b001, 32'h03, 32'h0, 1, 32'hFFFF_FFFF);
        chk("lh_mis_fault", {31'd0, flt_done}, 32'd1);
        chk("lh_mis_stall_req", st_cnt + rq_cnt, 0);
        run(1'b1, 1'b1, 3'b010, 32'h04, 32'h0, 1, 32'hFFFF_FFFF);
        chk("rdwr_fault", {31'd0, flt_done}, 32'd1);
        chk("rdwr_stall_req", st_cnt + rq_cnt, 0);
        run(1'b1, 1'b0, 3'b110, 32'h04, 32'h0, 1, 32'hFFFF_FFFF);
        chk("bad_f3_fault", {31'd0, flt_done}, 32'd1);
        chk("bad_f3_readdata", rd_done, 32'h0000_0080);
        @(negedge clk);
        chk("fault_one_cycle", {31'd0, fault}, 32'd0);
        @(posedge clk); #1;

        // Halfword loads from the upper lane
        run(1'b1, 1'b0, 3'b001, 32'h42, 32'h0, 1, 32'h8001_0000);
        chk("lh_data", rd_done, 32'hFFFF_8001);
        run(1'b1, 1'b0, 3'b101, 32'h42, 32'h0, 2, 32'h8001_0000);
        chk("lhu_data", rd_done, 32'h0000_8001);
        chk("lhu_stalls", st_cnt, 3);

        // Timeout after 4 REQ cycles
        run(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h5555_5555);
        chk("to_req_cycles", rq_cnt, 4);
        chk("to_fault", {31'd0, flt_done}, 32'd1);
        chk("to_readdata", rd_done, 32'd0);
        chk("to_stalls", st_cnt, 5);

        // Reset in the 2nd REQ cycle
        memread = 1'b1; funct3 = 3'b010; aluresult = 32'h100; bus_rdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_mid_stall_idle", {31'd0, stall}, 32'd1);
        memread = 1'b0;
        #1;
        chk("rst_mid_stall_noacc", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1, 32'h1122_3344);
        chk("post_rst_lw", rd_done, 32'h1122_3344);
        chk("post_rst_stalls", st_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
